mult4_accum: RTL and testbench
==============================

MULT4_ACCUM -- requirements
Module: mult4_accum

Interface
REQ-001 Parameter ACC_W, default 12, SHALL set accumulator and result width in bits (legal range 9..16).
REQ-002 Parameter MAX_TERMS, default 16, SHALL set the maximum number of products per accumulation (legal range 1..255).
REQ-003 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  SHALL be the synchronous, active-low reset, sampled on the rising edge of clk.
REQ-005 clr  input  1  SHALL be the synchronous abort that discards any accumulation in progress.
REQ-006 p_in  input  8  SHALL be the unsigned product from the upstream 4x4 multiplier.
REQ-007 in_valid  input  1  SHALL indicate that p_in is valid.
REQ-008 in_last  input  1  SHALL mark p_in as the final term of the current accumulation.
REQ-009 in_ready  output  1  SHALL indicate that the block can accept a term this cycle.
REQ-010 acc_out  output  ACC_W  SHALL be the accumulated sum.
REQ-011 term_cnt  output  8  SHALL be the number of terms in acc_out.
REQ-012 ovf  output  1  SHALL be the sticky overflow/saturation flag for the current result.
REQ-013 out_valid  output  1  SHALL indicate that acc_out, term_cnt and ovf hold a completed result.
REQ-014 out_ready  input  1  SHALL indicate that the downstream stage accepts the result.

Function
REQ-015 The block SHALL be a 3-state FSM: IDLE (no terms held), ACC (1 or more terms held, not finished), DONE (result held).
REQ-016 The block SHALL drive in_ready to 1 in IDLE and ACC and to 0 in DONE, using state only with no combinational path from any input.
REQ-017 The block SHALL accept a term on any edge where in_valid=1, in_ready=1 and clr=0; it SHALL ignore p_in and in_last on all other edges.
REQ-018 On an accept in IDLE, the block SHALL load acc_out=p_in (zero-extended), set term_cnt=1 and clear ovf.
REQ-019 On an accept in ACC, the block SHALL set acc_out=acc_out+p_in (computed ACC_W+1 wide) and increment term_cnt by 1.
REQ-020 If that sum exceeds 2^ACC_W-1, the block SHALL saturate acc_out to all ones and set ovf=1; ovf SHALL stay set until the result is consumed, cleared or reset.
REQ-021 Once saturated, acc_out SHALL remain all ones for further terms, and term_cnt SHALL still increment.
REQ-022 On an accept, the FSM SHALL go to DONE if in_last=1 or the new term_cnt equals MAX_TERMS; otherwise it SHALL go to (or stay in) ACC.
REQ-023 Latency: a finishing term accepted on edge k SHALL cause out_valid=1 from edge k through the cycle following it, with the final acc_out value.
REQ-024 In DONE, out_valid SHALL be 1 and acc_out, term_cnt and ovf SHALL hold stable until handshake completion.
REQ-025 The block SHALL complete the handshake on an edge where out_valid=1 and out_ready=1, then enter IDLE with out_valid=0, acc_out=0, term_cnt=0 and ovf=0.
REQ-026 out_ready SHALL be ignored outside DONE; out_valid SHALL be 0 in IDLE and ACC.
REQ-027 clr=1 on any edge SHALL force IDLE with all outputs at their reset values, including in DONE when out_ready=1 on the same edge (the result is dropped).
REQ-028 clr SHALL take priority over a simultaneous input accept; the term SHALL be discarded.
REQ-029 The block SHALL NOT accept a new term on the DONE->IDLE edge (in_ready=0 in DONE); the next term SHALL be accepted on the following cycle at the earliest.
REQ-030 With MAX_TERMS=1, every accepted term SHALL go directly to DONE.
REQ-031 The block SHALL be fully synchronous, with no latches and no combinational path between any input and any output.

Reset
REQ-032 rst_n=0 at a clock edge SHALL force IDLE with acc_out=0, term_cnt=0, ovf=0, out_valid=0 and in_ready=1.
REQ-033 Reset SHALL override clr and all handshakes, and SHALL abort an accumulation or held result mid-operation.
REQ-034 Outputs are undefined before the first reset edge; the bench SHALL apply rst_n=0 for at least 2 cycles.

Verification
REQ-035 Scenario 1: send 3 terms 15, 30, 225 with in_last on 225 and out_ready=1 -> out_valid for 1 cycle, acc_out=270, term_cnt=3, ovf=0.
REQ-036 Scenario 2: with ACC_W=9, send 225 x3 (last on the 3rd) -> acc_out=511, ovf=1, term_cnt=3.
REQ-037 Scenario 3: send 16 terms of 225 with no in_last -> DONE after the 16th, acc_out=3600, term_cnt=16; in_ready=0 while out_ready=0 for 5 cycles, and outputs stay stable.
REQ-038 Scenario 4: assert clr together with in_valid while in ACC (sum 40) -> IDLE, acc_out=0, term accepted only on a later cycle starting from 0.
REQ-039 Scenario 5: pulse rst_n=0 for 1 cycle while in DONE (result 100) -> out_valid=0, acc_out=0, in_ready=1 on the next cycle.
REQ-040 Scenario 6: random valid/ready gaps over 1000 accumulations checked against a reference model -> zero mismatches, no term lost or duplicated.

Source files
------------

// File: rtl/mult4_accum.sv
// rtl/mult4_accum.sv - saturating accumulator for 4x4 multiplier products
// Collects up to MAX_TERMS products and presents the sum with valid/ready handshake.
module mult4_accum #(
  parameter int ACC_W     = 12,
  parameter int MAX_TERMS = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic [7:0]       p_in,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic [ACC_W-1:0] acc_out,
  output logic [7:0]       term_cnt,
  output logic             ovf,
  output logic             out_valid,
  input  logic             out_ready
);

  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

  localparam logic [7:0] MAX_CNT = 8'(MAX_TERMS);

  state_t           state, state_nx;
  logic [ACC_W-1:0] acc_nx;
  logic [7:0]       cnt_nx;
  logic             ovf_nx;
  logic             accept;
  logic [ACC_W:0]   sum;
  logic [7:0]       cnt_inc;

  // Handshake outputs come from state alone, so no input reaches an output.
  assign in_ready  = (state != DONE);
  assign out_valid = (state == DONE);

  always_comb begin
    state_nx = state;
    acc_nx   = acc_out;
    cnt_nx   = term_cnt;
    ovf_nx   = ovf;
    accept   = in_valid && (state != DONE);
    sum      = {1'b0, acc_out} + {{(ACC_W-7){1'b0}}, p_in};
    cnt_inc  = term_cnt + 8'd1;
    case (state)
      IDLE: begin
        if (accept) begin
          acc_nx   = {{(ACC_W-8){1'b0}}, p_in};
          cnt_nx   = 8'd1;
          ovf_nx   = 1'b0;
          state_nx = (in_last || (MAX_CNT == 8'd1)) ? DONE : ACC;
        end
      end
      ACC: begin
        if (accept) begin
          // An all-ones accumulator stays all ones: any nonzero term overflows again.
          if (sum[ACC_W]) begin
            acc_nx = '1;
            ovf_nx = 1'b1;
          end else begin
            acc_nx = sum[ACC_W-1:0];
          end
          cnt_nx   = cnt_inc;
          state_nx = (in_last || (cnt_inc == MAX_CNT)) ? DONE : ACC;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_nx = IDLE;
          acc_nx   = '0;
          cnt_nx   = 8'd0;
          ovf_nx   = 1'b0;
        end
      end
      default: begin
        state_nx = IDLE;
        acc_nx   = '0;
        cnt_nx   = 8'd0;
        ovf_nx   = 1'b0;
      end
    endcase
  end

  // Reset and clr share one path; clr wins over any accept or handshake.
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      state    <= IDLE;
      acc_out  <= '0;
      term_cnt <= 8'd0;
      ovf      <= 1'b0;
    end else begin
      state    <= state_nx;
      acc_out  <= acc_nx;
      term_cnt <= cnt_nx;
      ovf      <= ovf_nx;
    end
  end

endmodule

// File: tb/tb_mult4_accum.sv
// tb/tb_mult4_accum.sv - scoreboard bench for mult4_accum
// Sum-of-terms reference model feeds a queue; a monitor checks each presented result.
module tb_mult4_accum;

  localparam int W    = 12;
  localparam int MAXV = (1 << W) - 1;
  localparam int MAXT = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0, clr = 1'b0, in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b0;
  logic [7:0] p_in = 8'd0;
  logic in_ready, ovf, out_valid;
  logic [W-1:0] acc_out;
  logic [7:0] term_cnt;

  logic [7:0] p9 = 8'd0;
  logic v9 = 1'b0, l9 = 1'b0, r9 = 1'b0, clr9 = 1'b0;
  logic rdy9, ovf9, ov9, rdy1, ovf1, ov1;
  logic [8:0] acc9;
  logic [11:0] acc1;
  logic [7:0] cnt9, cnt1;

  int tests = 0, fails = 0;
  bit mon_on = 0, accepted = 0;
  int m_sum = 0, m_n = 0;

  typedef struct {int acc; int cnt; int ovf;} res_t;
  res_t q[$];

  mult4_accum #(.ACC_W(W), .MAX_TERMS(MAXT)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .p_in(p_in), .in_valid(in_valid),
    .in_last(in_last), .in_ready(in_ready), .acc_out(acc_out), .term_cnt(term_cnt),
    .ovf(ovf), .out_valid(out_valid), .out_ready(out_ready));

  mult4_accum #(.ACC_W(9), .MAX_TERMS(16)) dut9 (
    .clk(clk), .rst_n(rst_n), .clr(clr9), .p_in(p9), .in_valid(v9),
    .in_last(l9), .in_ready(rdy9), .acc_out(acc9), .term_cnt(cnt9),
    .ovf(ovf9), .out_valid(ov9), .out_ready(r9));

  mult4_accum #(.ACC_W(12), .MAX_TERMS(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .clr(clr9), .p_in(p9), .in_valid(v9),
    .in_last(l9), .in_ready(rdy1), .acc_out(acc1), .term_cnt(cnt1),
    .ovf(ovf1), .out_valid(ov1), .out_ready(r9));

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One cycle: drive at the negedge, predict acceptance from the settled in_ready.
  task automatic cyc(input logic v, input logic [7:0] p, input logic l,
                     input logic c, input logic r, input logic ordy);
    res_t e;
    in_valid = v; p_in = p; in_last = l; clr = c; rst_n = r; out_ready = ordy;
    accepted = v && (in_ready === 1'b1) && !c && r;
    if (!r || c) begin
      m_n = 0;
    end else if (accepted) begin
      m_sum = (m_n == 0) ? int'(p) : m_sum + int'(p);
      m_n++;
      if (l || m_n == MAXT) begin
        e.acc = (m_sum > MAXV) ? MAXV : m_sum;
        e.cnt = m_n;
        e.ovf = (m_sum > MAXV) ? 1 : 0;
        q.push_back(e);
        m_n = 0;
      end
    end
    @(negedge clk);
  endtask

  task automatic send(input logic [7:0] p, input logic l, input int mode);
    int k = 0;
    accepted = 0;
    while (!accepted && k < 200) begin
      cyc(1'b1, p, l, 1'b0, 1'b1, (mode == 2) ? ($urandom % 2 != 0) : (mode != 0));
      k++;
    end
    if (!accepted) begin
      tests++; fails++;
      $display("FAIL send_timeout: term %0d not accepted within 200 cycles", p);
    end
  endtask

  initial begin : monitor
    bit prev = 0;
    res_t cur = '{0, 0, 0};
    forever begin
      @(negedge clk);
      #1;
      if (!mon_on) begin
        prev = 0;
      end else begin
        if (out_valid === 1'b1) begin
          if (!prev) begin
            if (q.size() == 0) begin
              tests++; fails++;
              $display("FAIL sb_unexpected: result acc %0d presented, none expected", acc_out);
            end else begin
              cur = q.pop_front();
            end
          end
          chk("sb_acc", int'(acc_out), cur.acc);
          chk("sb_cnt", int'(term_cnt), cur.cnt);
          chk("sb_ovf", int'(ovf), cur.ovf);
        end
        prev = (out_valid === 1'b1);
      end
    end
  end

  initial begin : driver
    repeat (3) @(negedge clk);
    chk("rst_acc", int'(acc_out), 0);
    chk("rst_cnt", int'(term_cnt), 0);
    chk("rst_ovf", int'(ovf), 0);
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_ready", int'(in_ready), 1);
    chk("rst_ready9", int'(rdy9), 1);
    rst_n = 1'b1;
    mon_on = 1;
    cyc(0, 0, 0, 0, 1, 0);

    // 15 + 30 + 225
    send(8'd15, 0, 1); send(8'd30, 0, 1); send(8'd225, 1, 1);
    chk("s1_valid", int'(out_valid), 1);
    chk("s1_acc", int'(acc_out), 270);
    chk("s1_cnt", int'(term_cnt), 3);
    chk("s1_ovf", int'(ovf), 0);
    cyc(0, 0, 0, 0, 1, 1);
    chk("s1_valid_one_cycle", int'(out_valid), 0);
    chk("s1_idle_acc", int'(acc_out), 0);

    // 9-bit saturation, and MAX_TERMS=1 on the same stimulus
    v9 = 1; p9 = 8'd225; l9 = 0; r9 = 0;
    @(negedge clk); @(negedge clk);
    l9 = 1; @(negedge clk);
    v9 = 0; l9 = 0;
    chk("s2_valid", int'(ov9), 1);
    chk("s2_acc", int'(acc9), 511);
    chk("s2_ovf", int'(ovf9), 1);
    chk("s2_cnt", int'(cnt9), 3);
    chk("m1_valid", int'(ov1), 1);
    chk("m1_acc", int'(acc1), 225);
    chk("m1_cnt", int'(cnt1), 1);
    chk("m1_ovf", int'(ovf1), 0);
    r9 = 1; @(negedge clk); r9 = 0;
    chk("s2_cleared", int'(ov9), 0);
    chk("s2_cleared_acc", int'(acc9), 0);

    // 16 terms without in_last, then stall 5 cycles
    for (int i = 0; i < 16; i++) send(8'd225, 0, 0);
    chk("s3_valid", int'(out_valid), 1);
    chk("s3_acc", int'(acc_out), 3600);
    chk("s3_cnt", int'(term_cnt), 16);
    for (int i = 0; i < 5; i++) begin
      cyc(1, 8'd9, 0, 0, 1, 0);
      chk("s3_in_ready_low", int'(in_ready), 0);
      chk("s3_hold_acc", int'(acc_out), 3600);
    end
    cyc(0, 0, 0, 0, 1, 1);
    chk("s3_consumed", int'(out_valid), 0);

    // clr beats a simultaneous accept
    send(8'd15, 0, 1); send(8'd25, 0, 1);
    chk("s4_pre_acc", int'(acc_out), 40);
    cyc(1, 8'd7, 0, 1, 1, 1);
    chk("s4_acc", int'(acc_out), 0);
    chk("s4_cnt", int'(term_cnt), 0);
    chk("s4_ready", int'(in_ready), 1);
    send(8'd5, 1, 1);
    chk("s4_restart_acc", int'(acc_out), 5);
    chk("s4_restart_cnt", int'(term_cnt), 1);
    cyc(0, 0, 0, 0, 1, 1);

    // reset pulse while holding a result
    send(8'd100, 1, 0);
    chk("s5_valid", int'(out_valid), 1);
    chk("s5_acc_held", int'(acc_out), 100);
    cyc(0, 0, 0, 0, 0, 0);
    chk("s5_valid", int'(out_valid), 0);
    chk("s5_acc", int'(acc_out), 0);
    chk("s5_ready", int'(in_ready), 1);

    // randomized accumulations with gaps, clears and back-pressure
    for (int a = 0; a < 1000; a++) begin
      int len = $urandom_range(1, 18);
      for (int t = 0; t < len; t++) begin
        if ($urandom % 4 == 0)
          cyc(1'b0, 8'($urandom), ($urandom % 2 != 0), ($urandom % 100 == 0), 1'b1,
              ($urandom % 2 != 0));
        send(8'($urandom_range(0, 15) * $urandom_range(0, 15)), (t == len - 1), 2);
      end
    end
    repeat (4) cyc(0, 0, 0, 0, 1, 1);
    chk("sb_empty", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
